// File: rtl/bank_timing_pkg.sv
// Shared types for the per-bank DRAM timing tracker: state codes, decoded
// per-bank command, and the strobe priority encoder.
package bank_timing_pkg;

  localparam int unsigned CntWidth = 8;

  typedef enum logic [4:0] {
    StIdle        = 5'h00,
    StActivating  = 5'h01,
    StActive      = 5'h03,
    StPowerDown   = 5'h07,
    StPrecharging = 5'h0A,
    StReading     = 5'h0B,
    StReadingAp   = 5'h0C,
    StRefreshing  = 5'h0D,
    StWriting     = 5'h12,
    StWritingAp   = 5'h13
  } bank_state_e;

  typedef enum logic [2:0] {
    CmdNone = 3'd0,
    CmdAct  = 3'd1,
    CmdRd   = 3'd2,
    CmdWr   = 3'd3,
    CmdRda  = 3'd4,
    CmdWra  = 3'd5,
    CmdPr   = 3'd6
  } bank_cmd_e;

  // Addressed-command priority: PR > WRA > RDA > WR > RD > ACT.
  function automatic bank_cmd_e cmd_priority(input logic pr, input logic wra, input logic rda,
                                             input logic wr, input logic rd, input logic act);
    if (pr)  return CmdPr;
    if (wra) return CmdWra;
    if (rda) return CmdRda;
    if (wr)  return CmdWr;
    if (rd)  return CmdRd;
    if (act) return CmdAct;
    return CmdNone;
  endfunction

  function automatic logic is_open(input bank_state_e s);
    return (s == StActive) || (s == StReading) || (s == StWriting);
  endfunction

endpackage

// File: rtl/bank_fsm_unit.sv
// One bank's timing state machine: state register plus 8-bit down-counter.
// Power-down states exist only when POWER_DOWN_EN is defined.
module bank_fsm_unit
  import bank_timing_pkg::*;
#(
  parameter int unsigned BL    = 8,
  parameter int unsigned T_RCD = 17,
  parameter int unsigned T_WR  = 14,
  parameter int unsigned T_RP  = 17,
  parameter int unsigned T_RFC = 34
) (
  input  logic       clk,
  input  logic       reset_n,
  input  bank_cmd_e  cmd,
  input  logic       pra,
  input  logic       ref_all,
  input  logic       pd_all,
  input  logic       pdx_all,
  output logic [4:0] state
);

  // Counters hold (duration - 1); the transition fires on the edge after reaching zero.
  localparam logic [CntWidth-1:0] RcdLoad = CntWidth'(T_RCD - 1);
  localparam logic [CntWidth-1:0] RdaLoad = CntWidth'(BL + 1);
  localparam logic [CntWidth-1:0] WraLoad = CntWidth'(T_WR + 1);
  localparam logic [CntWidth-1:0] RpLoad  = CntWidth'(T_RP - 1);
  localparam logic [CntWidth-1:0] RfcLoad = CntWidth'(T_RFC - 1);

  bank_state_e         state_q;
  logic [CntWidth-1:0] cnt_q;
  logic                cnt_done;

  assign cnt_done = (cnt_q == '0);
  assign state    = state_q;

`ifndef POWER_DOWN_EN
  logic unused_pd;
  assign unused_pd = pd_all ^ pdx_all;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ref_all) begin
            state_q <= StRefreshing;
            cnt_q   <= RfcLoad;
`ifdef POWER_DOWN_EN
          end else if (pd_all) begin
            state_q <= StPowerDown;
`endif
          end else if (cmd == CmdAct) begin
            state_q <= StActivating;
            cnt_q   <= RcdLoad;
          end
        end
        StActive, StReading, StWriting: begin
          if (pra) begin
            state_q <= StPrecharging;
            cnt_q   <= RpLoad;
          end else begin
            case (cmd)
              CmdPr: begin
                state_q <= StPrecharging;
                cnt_q   <= RpLoad;
              end
              CmdWra: begin
                state_q <= StWritingAp;
                cnt_q   <= WraLoad;
              end
              CmdRda: begin
                state_q <= StReadingAp;
                cnt_q   <= RdaLoad;
              end
              CmdWr:   state_q <= StWriting;
              CmdRd:   state_q <= StReading;
              default: ;
            endcase
          end
        end
        StActivating: begin
          if (cnt_done) state_q <= StActive;
          else          cnt_q   <= cnt_q - CntWidth'(1);
        end
        StReadingAp, StWritingAp: begin
          if (cnt_done) begin
            state_q <= StPrecharging;
            cnt_q   <= RpLoad;
          end else begin
            cnt_q <= cnt_q - CntWidth'(1);
          end
        end
        StPrecharging, StRefreshing: begin
          if (cnt_done) state_q <= StIdle;
          else          cnt_q   <= cnt_q - CntWidth'(1);
        end
`ifdef POWER_DOWN_EN
        StPowerDown: begin
          if (pdx_all) state_q <= StIdle;
        end
`endif
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bank_timing_fsm.sv
// Per-bank DDR3/DDR4 timing tracker: strobe priority, bank address decode and one
// bank_fsm_unit per bank. Optional power-down support via POWER_DOWN_EN.
module bank_timing_fsm
  import bank_timing_pkg::*;
#(
  parameter int unsigned BGWIDTH = 2,
  parameter int unsigned BAWIDTH = 2,
  parameter int unsigned BL      = 8,
  parameter int unsigned T_CL    = 17,
  parameter int unsigned T_RCD   = 17,
  parameter int unsigned T_WR    = 14,
  parameter int unsigned T_RP    = 17,
  parameter int unsigned T_RFC   = 34
) (
  input  logic                                               clk,
  input  logic                                               reset_n,
  input  logic [((BGWIDTH > 0) ? BGWIDTH : 1)-1:0]           bg,
  input  logic [BAWIDTH-1:0]                                 ba,
  input  logic                                               ACT,
  input  logic                                               BST,
  input  logic                                               CFG,
  input  logic                                               CKEH,
  input  logic                                               CKEL,
  input  logic                                               DPD,
  input  logic                                               DPDX,
  input  logic                                               MRR,
  input  logic                                               MRW,
  input  logic                                               PD,
  input  logic                                               PDX,
  input  logic                                               PR,
  input  logic                                               PRA,
  input  logic                                               RD,
  input  logic                                               RDA,
  input  logic                                               REF,
  input  logic                                               SRF,
  input  logic                                               WR,
  input  logic                                               WRA,
  output logic [(2**BGWIDTH)-1:0][(2**BAWIDTH)-1:0][4:0]     BankFSM
);

  localparam int unsigned BankGroups    = 2**BGWIDTH;
  localparam int unsigned BanksPerGroup = 2**BAWIDTH;
  localparam int unsigned BgBits        = (BGWIDTH > 0) ? BGWIDTH : 1;

  if (T_CL < 2 || T_RCD < 2 || T_WR < 2 || T_RP < 2 || T_RFC < 2 ||
      T_CL > 256 || T_RCD > 256 || T_RP > 256 || T_RFC > 256 ||
      BL + 2 > 256 || T_WR + 2 > 256) begin : gen_bad_params
    $error("bank_timing_fsm: timing parameters must lie in 2..256");
  end

  logic      all_bank_cmd;
  logic      ref_all;
  logic      pd_all;
  logic      pdx_all;
  bank_cmd_e cmd_sel;

  // All-bank PRA/REF pre-empt every addressed command in the same cycle.
  assign all_bank_cmd = PRA | REF;
  assign ref_all      = REF & ~PRA;
  assign cmd_sel      = all_bank_cmd ? CmdNone : cmd_priority(PR, WRA, RDA, WR, RD, ACT);

`ifdef POWER_DOWN_EN
  logic all_idle;

  always_comb begin
    all_idle = 1'b1;
    for (int g = 0; g < int'(BankGroups); g++) begin
      for (int b = 0; b < int'(BanksPerGroup); b++) begin
        if (BankFSM[g][b] != StIdle) all_idle = 1'b0;
      end
    end
  end

  // PD ranks below every other strobe and needs a fully idle device.
  assign pd_all  = PD & all_idle & ~all_bank_cmd & (cmd_sel == CmdNone);
  assign pdx_all = PDX;

  logic unused_strobes;
  assign unused_strobes = ^{BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, SRF};
`else
  assign pd_all  = 1'b0;
  assign pdx_all = 1'b0;

  logic unused_strobes;
  assign unused_strobes = ^{BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, SRF, PD, PDX};
`endif

  for (genvar g = 0; g < BankGroups; g++) begin : gen_group
    for (genvar b = 0; b < BanksPerGroup; b++) begin : gen_bank
      logic      hit;
      bank_cmd_e bank_cmd;

      assign hit      = ((BGWIDTH == 0) || (bg == BgBits'(g))) && (ba == BAWIDTH'(b));
      assign bank_cmd = hit ? cmd_sel : CmdNone;

      bank_fsm_unit #(
        .BL    (BL),
        .T_RCD (T_RCD),
        .T_WR  (T_WR),
        .T_RP  (T_RP),
        .T_RFC (T_RFC)
      ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .cmd     (bank_cmd),
        .pra     (PRA),
        .ref_all (ref_all),
        .pd_all  (pd_all),
        .pdx_all (pdx_all),
        .state   (BankFSM[g][b])
      );
    end
  end

endmodule

// File: tb/tb_bank_timing_fsm.sv
// Self-checking bench for bank_timing_fsm: directed scenarios plus random command
// traffic, checked every cycle against a schedule-based model of each bank.
module tb_bank_timing_fsm;

  localparam int BL = 8, T_CL = 17, T_RCD = 17, T_WR = 14, T_RP = 17, T_RFC = 34;
  localparam int NEVER = 32'h7fff_ffff;
  localparam int SPRA = 0, SREF = 1, SPR = 2, SWRA = 3, SRDA = 4, SWR = 5, SRD = 6, SACT = 7;
  localparam int SPD = 8, SPDX = 9, SBST = 10, SCFG = 11, SCKEH = 12, SCKEL = 13, SDPD = 14;
  localparam int SDPDX = 15, SMRR = 16, SMRW = 17, SSRF = 18;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [1:0]           bg = '0;
  logic [1:0]           ba = '0;
  logic [18:0]          strb = '0;
  logic [3:0][3:0][4:0] bank_fsm;

  // Model: each bank follows up to three scheduled codes c0 -> c1 (at t1) -> c2 (at t2).
  logic [4:0] c0 [16];
  logic [4:0] c1 [16];
  logic [4:0] c2 [16];
  int         t1 [16];
  int         t2 [16];
  int         cyc;
  int         n_checks = 0;
  int         n_fails = 0;

  bank_timing_fsm #(
    .BGWIDTH (2), .BAWIDTH (2), .BL (BL), .T_CL (T_CL),
    .T_RCD (T_RCD), .T_WR (T_WR), .T_RP (T_RP), .T_RFC (T_RFC)
  ) dut (
    .clk (clk), .reset_n (reset_n), .bg (bg), .ba (ba),
    .ACT (strb[SACT]), .BST (strb[SBST]), .CFG (strb[SCFG]), .CKEH (strb[SCKEH]),
    .CKEL (strb[SCKEL]), .DPD (strb[SDPD]), .DPDX (strb[SDPDX]), .MRR (strb[SMRR]),
    .MRW (strb[SMRW]), .PD (strb[SPD]), .PDX (strb[SPDX]), .PR (strb[SPR]),
    .PRA (strb[SPRA]), .RD (strb[SRD]), .RDA (strb[SRDA]), .REF (strb[SREF]),
    .SRF (strb[SSRF]), .WR (strb[SWR]), .WRA (strb[SWRA]), .BankFSM (bank_fsm)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] exp_state(input int k, input int n);
    if (n >= t2[k]) return c2[k];
    if (n >= t1[k]) return c1[k];
    return c0[k];
  endfunction

  function automatic bit open_st(input logic [4:0] s);
    return (s == 5'h03) || (s == 5'h0B) || (s == 5'h12);
  endfunction

  function automatic logic [18:0] sb(input int i);
    logic [18:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Schedule offsets d1/d2 are in clocks from the current edge; negative means never.
  task automatic set_sched(input int k, input logic [4:0] a, input int d1, input logic [4:0] b,
                           input int d2, input logic [4:0] c);
    c0[k] = a; c1[k] = b; c2[k] = c;
    t1[k] = (d1 < 0) ? NEVER : cyc + d1;
    t2[k] = (d2 < 0) ? NEVER : cyc + d2;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) set_sched(k, 5'h00, -1, 5'h00, -1, 5'h00);
  endtask

  task automatic model_edge();
    logic [4:0] pre [16];
    int  tgt;
    bit  all_idle;
    bit  all_pd;
    tgt = int'(bg) * 4 + int'(ba);
    all_idle = 1'b1;
    all_pd = 1'b1;
    for (int k = 0; k < 16; k++) begin
      pre[k] = exp_state(k, cyc - 1);
      if (pre[k] != 5'h00) all_idle = 1'b0;
      if (pre[k] != 5'h07) all_pd = 1'b0;
    end
    if (strb[SPRA]) begin
      for (int k = 0; k < 16; k++)
        if (open_st(pre[k])) set_sched(k, 5'h0A, T_RP, 5'h00, -1, 5'h00);
    end else if (strb[SREF]) begin
      for (int k = 0; k < 16; k++)
        if (pre[k] == 5'h00) set_sched(k, 5'h0D, T_RFC, 5'h00, -1, 5'h00);
    end else if (strb[SPR]) begin
      if (open_st(pre[tgt])) set_sched(tgt, 5'h0A, T_RP, 5'h00, -1, 5'h00);
    end else if (strb[SWRA]) begin
      if (open_st(pre[tgt])) set_sched(tgt, 5'h13, T_WR + 2, 5'h0A, T_WR + 2 + T_RP, 5'h00);
    end else if (strb[SRDA]) begin
      if (open_st(pre[tgt])) set_sched(tgt, 5'h0C, BL + 2, 5'h0A, BL + 2 + T_RP, 5'h00);
    end else if (strb[SWR]) begin
      if (open_st(pre[tgt])) set_sched(tgt, 5'h12, -1, 5'h12, -1, 5'h12);
    end else if (strb[SRD]) begin
      if (open_st(pre[tgt])) set_sched(tgt, 5'h0B, -1, 5'h0B, -1, 5'h0B);
    end else if (strb[SACT]) begin
      if (pre[tgt] == 5'h00) set_sched(tgt, 5'h01, T_RCD, 5'h03, -1, 5'h03);
`ifdef POWER_DOWN_EN
    end else if (strb[SPD]) begin
      if (all_idle) for (int k = 0; k < 16; k++) set_sched(k, 5'h07, -1, 5'h07, -1, 5'h07);
`endif
    end
`ifdef POWER_DOWN_EN
    if (strb[SPDX] && all_pd)
      for (int k = 0; k < 16; k++) set_sched(k, 5'h00, -1, 5'h00, -1, 5'h00);
`endif
  endtask

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < 4; g++)
      for (int b = 0; b < 4; b++)
        check($sformatf("bank[%0d][%0d]", g, b), bank_fsm[g][b], exp_state(g * 4 + b, cyc));
  endtask

  // Called at a negedge: drive, clock once, update model, then compare at the next negedge.
  task automatic tick(input logic [18:0] s, input logic [1:0] g, input logic [1:0] b);
    strb = s; bg = g; ba = b;
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    strb = '0;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick('0, 2'd0, 2'd0);
  endtask

  initial begin
    logic [18:0] s;
    int r;
    cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;

    // 1: activate bank [1][1]
    tick(sb(SACT), 2'd1, 2'd1);
    check("act_first", bank_fsm[1][1], 5'h01);
    idle(T_RCD - 1);
    check("act_last", bank_fsm[1][1], 5'h01);
    idle(1);
    check("act_done", bank_fsm[1][1], 5'h03);
    check("act_other", bank_fsm[0][0], 5'h00);

    // 2: WR / RD / WR / PR on the open bank
    tick(sb(SWR), 2'd1, 2'd1);
    idle(16);
    check("wr_hold", bank_fsm[1][1], 5'h12);
    tick(sb(SRD), 2'd1, 2'd1);
    idle(BL + 1);
    check("rd_hold", bank_fsm[1][1], 5'h0B);
    tick(sb(SWR), 2'd1, 2'd1);
    tick(sb(SPR), 2'd1, 2'd1);
    check("pr_enter", bank_fsm[1][1], 5'h0A);
    idle(T_RP);
    check("pr_done", bank_fsm[1][1], 5'h00);

    // 3: all-bank refresh
    tick(sb(SREF), 2'd3, 2'd2);
    check("ref_enter", bank_fsm[2][0], 5'h0D);
    idle(T_RFC);
    check("ref_done", bank_fsm[3][3], 5'h00);

    // 4: WRA then RDA auto-precharge sequences
    tick(sb(SACT), 2'd2, 2'd3);
    idle(T_RCD);
    tick(sb(SWRA), 2'd2, 2'd3);
    idle(T_WR + 1);
    check("wra_last", bank_fsm[2][3], 5'h13);
    idle(1);
    check("wra_pre", bank_fsm[2][3], 5'h0A);
    idle(T_RP);
    check("wra_done", bank_fsm[2][3], 5'h00);
    tick(sb(SACT), 2'd2, 2'd3);
    idle(T_RCD);
    tick(sb(SRDA), 2'd2, 2'd3);
    idle(BL + 1);
    check("rda_last", bank_fsm[2][3], 5'h0C);
    idle(1);
    check("rda_pre", bank_fsm[2][3], 5'h0A);
    idle(T_RP);

    // 5: illegal commands and same-cycle priority
    tick(sb(SRD), 2'd0, 2'd0);
    check("rd_idle", bank_fsm[0][0], 5'h00);
    tick(sb(SACT), 2'd0, 2'd0);
    tick(sb(SPR), 2'd0, 2'd0);
    check("pr_activating", bank_fsm[0][0], 5'h01);
    idle(T_RCD);
    tick(sb(SACT), 2'd0, 2'd0);
    check("act_active", bank_fsm[0][0], 5'h03);
    tick(sb(SACT) | sb(SPR), 2'd0, 2'd0);
    check("pr_wins", bank_fsm[0][0], 5'h0A);
    idle(T_RP);

    // Random traffic, including multi-strobe cycles and ignored strobes
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      s = '0;
      if (r < 2)       s = sb(SPRA);
      else if (r < 4)  s = sb(SREF);
      else if (r < 10) s = sb(SPR);
      else if (r < 14) s = sb(SWRA);
      else if (r < 18) s = sb(SRDA);
      else if (r < 28) s = sb(SWR);
      else if (r < 38) s = sb(SRD);
      else if (r < 70) s = sb(SACT);
      if ($urandom_range(0, 9) == 0) s = s | sb($urandom_range(0, 18));
      tick(s, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    // 6: asynchronous reset in the middle of a refresh
    idle(60);
    tick(sb(SPRA), 2'd0, 2'd0);
    idle(T_RP);
    tick(sb(SREF), 2'd0, 2'd0);
    idle(5);
    check("ref_mid", bank_fsm[1][2], 5'h0D);
    @(posedge clk);
    cyc++;
    #3 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);

`ifdef POWER_DOWN_EN
    tick(sb(SPD), 2'd0, 2'd0);
    check("pd_enter", bank_fsm[3][1], 5'h07);
    tick(sb(SACT), 2'd1, 2'd1);
    check("pd_ignore", bank_fsm[1][1], 5'h07);
    tick(sb(SPDX), 2'd0, 2'd0);
    check("pd_exit", bank_fsm[3][1], 5'h00);
`else
    tick(sb(SPD), 2'd0, 2'd0);
    check("pd_off", bank_fsm[3][1], 5'h00);
`endif
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
